// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall sequencer and shared RAM port arbiter
//
// Purpose: owns the six-bit stall vector for the 5-stage core and time-shares
// the single instruction/data RAM port between IF fetches and MEM load/stores.
//
// Ports:
//   clk_i          system clock, all state on rising edge
//   rst_i          asynchronous active-high reset
//   stallreq_id_i  ID load-use hazard request
//   stallreq_ex_i  EX multi-cycle op request
//   if_req_i       IF wants an instruction word
//   data_req_i     MEM holds a load/store
//   data_we_i      MEM access is a store (sampled with data_req_i)
//   stall_o[5:0]   [0]=pc [1]=if_id [2]=id_ex [3]=ex_mem [4]=mem_wb [5]=wb, 1=hold
//   ram_en_o       shared RAM port active
//   ram_sel_o      0=instruction address, 1=data address
//   ram_we_o       RAM write strobe
//   inst_done_o    fetch word valid on RAM output (one-cycle pulse)
//   data_done_o    load data valid / store committed (one-cycle pulse)
module pipe_ctrl #(
   parameter int MEM_WAIT = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       stallreq_id_i,
   input  logic       stallreq_ex_i,
   input  logic       if_req_i,
   input  logic       data_req_i,
   input  logic       data_we_i,
   output logic [5:0] stall_o,
   output logic       ram_en_o,
   output logic       ram_sel_o,
   output logic       ram_we_o,
   output logic       inst_done_o,
   output logic       data_done_o
);

   localparam int CW = $clog2(MEM_WAIT) + 1;
   localparam logic [CW-1:0] LAST = CW'(MEM_WAIT - 1);

   typedef enum logic [1:0] {IDLE, INST, DATA} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic            data_we_q;
   logic            ram_en_q, ram_sel_q, ram_we_q;
   logic            terminal;
   logic            decide;
   logic            mem_busy, if_busy;

   assign terminal    = (state_q != IDLE) && (cnt_q == LAST);
   // A new access may only be chosen from IDLE or on the last cycle of one.
   assign decide      = (state_q == IDLE) || terminal;
   assign inst_done_o = (state_q == INST) && terminal;
   assign data_done_o = (state_q == DATA) && terminal;

   assign mem_busy = data_req_i & ~data_done_o;
   assign if_busy  = if_req_i & ~inst_done_o;

   always_comb begin
      if (mem_busy)           stall_o = 6'b011111;
      else if (stallreq_ex_i) stall_o = 6'b001111;
      else if (stallreq_id_i) stall_o = 6'b000111;
      else if (if_busy)       stall_o = 6'b000011;
      else                    stall_o = 6'b000000;
   end

   // Data wins over fetch; a fetch is not started while ID/EX are holding
   // the pc, since that word could not be consumed.
   always_comb begin
      state_d = state_q;
      if (decide) begin
         if (data_req_i)
            state_d = DATA;
         else if (if_req_i && !stallreq_ex_i && !stallreq_id_i)
            state_d = INST;
         else
            state_d = IDLE;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         data_we_q <= 1'b0;
         ram_en_q  <= 1'b0;
         ram_sel_q <= 1'b0;
         ram_we_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         // Cleared on every entry, including INST->INST / DATA->DATA re-entry.
         if (decide) cnt_q <= '0;
         else        cnt_q <= cnt_q + CW'(1);
         if (decide && state_d == DATA)
            data_we_q <= data_we_i;
         ram_en_q  <= (state_d != IDLE);
         ram_sel_q <= (state_d == DATA);
         if (state_d == DATA)
            ram_we_q <= decide ? data_we_i : data_we_q;
         else
            ram_we_q <= 1'b0;
      end
   end

   assign ram_en_o  = ram_en_q;
   assign ram_sel_o = ram_sel_q;
   assign ram_we_o  = ram_we_q;

endmodule
